lc3b_mem_arbiter: RTL and testbench

Two-port to one-port physical-memory arbiter for the pipelined LC-3b core. It sits between the instruction cache (fetch stage, read-only) and the data cache (MEM stage, read/write) on one side, and the single shared physical-memory port on the other. It serializes line transfers with a three-state FSM and breaks ties with round-robin. It also keeps saturating wait-cycle counters per requester for pipeline stall analysis.

---
 rtl/lc3b_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_lc3b_mem_arbiter.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_mem_arbiter.sv
// Shares one physical-memory port between the LC-3b I-cache and D-cache.
// Line transfers are serialized by a 3-state FSM with round-robin tie-break.
module lc3b_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  input  logic              stat_clear,
  output logic [15:0]       i_wait_cnt,
  output logic [15:0]       d_wait_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_I = 2'd1,
    ST_SERVE_D = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_last_grant_d;
  logic                r_pmem_read;
  logic                r_pmem_write;
  logic [ADDR_W-1:0]   r_pmem_address;
  logic [LINE_W-1:0]   r_pmem_wdata;
  logic [15:0]         r_i_wait_cnt;
  logic [15:0]         r_d_wait_cnt;

  logic w_i_req;
  logic w_d_req;
  logic w_grant_d;
  logic w_grant_i;
  logic w_i_waiting;
  logic w_d_waiting;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;

  // On a tie the port that did not win last time is granted.
  assign w_grant_d = w_d_req & (~w_i_req | ~r_last_grant_d);
  assign w_grant_i = w_i_req & ~w_grant_d;

  assign w_i_waiting = w_i_req & (r_state != ST_SERVE_I);
  assign w_d_waiting = w_d_req & (r_state != ST_SERVE_D);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_last_grant_d <= 1'b0;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_d) begin
            r_state        <= ST_SERVE_D;
            r_last_grant_d <= 1'b1;
            r_pmem_address <= d_address;
            r_pmem_wdata   <= d_wdata;
            // Simultaneous read and write from the D-cache is a writeback.
            r_pmem_write   <= d_write;
            r_pmem_read    <= ~d_write;
          end else if (w_grant_i) begin
            r_state        <= ST_SERVE_I;
            r_last_grant_d <= 1'b0;
            r_pmem_address <= i_address;
            r_pmem_read    <= 1'b1;
            r_pmem_write   <= 1'b0;
          end
        end
        ST_SERVE_I, ST_SERVE_D: begin
          if (pmem_resp) begin
            r_state      <= ST_IDLE;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_pmem_read  <= 1'b0;
          r_pmem_write <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_i_wait_cnt <= '0;
      r_d_wait_cnt <= '0;
    end else if (stat_clear) begin
      r_i_wait_cnt <= '0;
      r_d_wait_cnt <= '0;
    end else begin
      if (w_i_waiting && (r_i_wait_cnt != 16'hFFFF)) begin
        r_i_wait_cnt <= r_i_wait_cnt + 16'd1;
      end
      if (w_d_waiting && (r_d_wait_cnt != 16'hFFFF)) begin
        r_d_wait_cnt <= r_d_wait_cnt + 16'd1;
      end
    end
  end

  // Completion is routed straight through so the cache sees it in the pmem_resp cycle.
  assign i_resp       = (r_state == ST_SERVE_I) & pmem_resp;
  assign d_resp       = (r_state == ST_SERVE_D) & pmem_resp;
  assign i_rdata      = pmem_rdata;
  assign d_rdata      = pmem_rdata;
  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_pmem_address;
  assign pmem_wdata   = r_pmem_wdata;
  assign i_wait_cnt   = r_i_wait_cnt;
  assign d_wait_cnt   = r_d_wait_cnt;

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Self-checking bench for lc3b_mem_arbiter: latency-programmable memory model,
// response scoreboard and one task per scenario.
module tb_lc3b_mem_arbiter;

  logic         clk;
  logic         reset;
  logic         i_read;
  logic [15:0]  i_address;
  logic [127:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [15:0]  d_address;
  logic [127:0] d_wdata;
  logic [127:0] d_rdata;
  logic         d_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic         stat_clear;
  logic [15:0]  i_wait_cnt;
  logic [15:0]  d_wait_cnt;

  int checks;
  int failures;
  int mem_lat;
  int mem_cnt;
  int n_i_resp;
  int n_d_resp;
  bit prev_resp;

  typedef struct {
    bit          is_d;
    logic [15:0] addr;
    bit          wr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  lc3b_mem_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .stat_clear(stat_clear), .i_wait_cnt(i_wait_cnt), .d_wait_cnt(d_wait_cnt)
  );

  function automatic logic [127:0] data_for(input logic [15:0] a);
    return {8{a ^ 16'hA5C3}};
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: responds mem_lat cycles after it first sees a strobe.
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    mem_cnt    = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset || pmem_resp) begin
        pmem_resp  = 1'b0;
        mem_cnt    = 0;
        pmem_rdata = {4{$urandom}};
      end else if (pmem_read || pmem_write) begin
        mem_cnt++;
        if (mem_cnt >= mem_lat) begin
          pmem_resp  = 1'b1;
          pmem_rdata = data_for(pmem_address);
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on every resp pulse.
  initial begin
    prev_resp = 1'b0;
    n_i_resp  = 0;
    n_d_resp  = 0;
    forever begin
      @(negedge clk);
      if (prev_resp) begin
        checks++;
        if ((pmem_read | pmem_write) !== 1'b0) begin
          failures++;
          $display("FAIL turnaround: strobes rd=%b wr=%b required rd=0 wr=0", pmem_read, pmem_write);
        end
      end
      if (i_resp === 1'b1 || d_resp === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp: i_resp=%b d_resp=%b required no response", i_resp, d_resp);
        end else begin
          mon_e = sb.pop_front();
          checks++;
          if ({i_resp, d_resp} !== (mon_e.is_d ? 2'b01 : 2'b10)) begin
            failures++;
            $display("FAIL grant_port: {i_resp,d_resp}=%b required %b", {i_resp, d_resp},
                     mon_e.is_d ? 2'b01 : 2'b10);
          end
          checks++;
          if (pmem_address !== mon_e.addr) begin
            failures++;
            $display("FAIL resp_address: pmem_address=%h required %h", pmem_address, mon_e.addr);
          end
          checks++;
          if ({pmem_read, pmem_write} !== (mon_e.wr ? 2'b01 : 2'b10)) begin
            failures++;
            $display("FAIL resp_op: {rd,wr}=%b required %b", {pmem_read, pmem_write},
                     mon_e.wr ? 2'b01 : 2'b10);
          end
          if (!mon_e.wr) begin
            checks++;
            if ((mon_e.is_d ? d_rdata : i_rdata) !== data_for(mon_e.addr)) begin
              failures++;
              $display("FAIL resp_rdata: got %h required %h",
                       mon_e.is_d ? d_rdata : i_rdata, data_for(mon_e.addr));
            end
          end
        end
        if (i_resp === 1'b1) n_i_resp++;
        if (d_resp === 1'b1) n_d_resp++;
      end
      prev_resp = (i_resp === 1'b1) || (d_resp === 1'b1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drops each request at the negedge its resp is seen, then waits for the queue to drain.
  task automatic wait_done(input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (i_resp) i_read = 1'b0;
      if (d_resp) begin
        d_read  = 1'b0;
        d_write = 1'b0;
      end
      if (!i_read && !d_read && !d_write) done = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (!done || sb.size() != 0) begin
      failures++;
      $display("FAIL wait_done: done=%0d pending=%0d required done=1 pending=0", done, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_strobes: rd=%b wr=%b i_resp=%b d_resp=%b required all 0",
               pmem_read, pmem_write, i_resp, d_resp);
    end
    checks++;
    if (pmem_address !== 16'h0 || pmem_wdata !== 128'h0) begin
      failures++;
      $display("FAIL reset_latches: addr=%h wdata=%h required 0", pmem_address, pmem_wdata);
    end
    checks++;
    if (i_wait_cnt !== 16'h0 || d_wait_cnt !== 16'h0) begin
      failures++;
      $display("FAIL reset_counters: i=%h d=%h required 0", i_wait_cnt, d_wait_cnt);
    end
    reset = 1'b0;
  endtask

  task automatic test_lone_i_read();
    int ni0, nd0;
    ni0 = n_i_resp;
    nd0 = n_d_resp;
    mem_lat = 3;
    @(negedge clk);
    i_address = 16'h1230;
    i_read    = 1'b1;
    sb.push_back('{is_d: 1'b0, addr: 16'h1230, wr: 1'b0});
    @(negedge clk);
    checks++;
    if ({pmem_read, pmem_write} !== 2'b10 || pmem_address !== 16'h1230) begin
      failures++;
      $display("FAIL lone_i_grant: rd=%b wr=%b addr=%h required rd=1 wr=0 addr=1230",
               pmem_read, pmem_write, pmem_address);
    end
    wait_done(20);
    checks++;
    if (n_i_resp - ni0 != 1 || n_d_resp - nd0 != 0) begin
      failures++;
      $display("FAIL lone_i_pulses: i=%0d d=%0d required i=1 d=0", n_i_resp - ni0, n_d_resp - nd0);
    end
    checks++;
    if (i_wait_cnt !== 16'd1 || d_wait_cnt !== 16'd0) begin
      failures++;
      $display("FAIL lone_i_wait: i=%0d d=%0d required i=1 d=0", i_wait_cnt, d_wait_cnt);
    end
  endtask

  task automatic test_d_write();
    logic [127:0] wd;
    wd = 128'hDEADBEEF_01234567_89ABCDEF_CAFEBEEF;
    mem_lat = 4;
    @(negedge clk);
    d_address = 16'h4440;
    d_wdata   = wd;
    d_write   = 1'b1;
    sb.push_back('{is_d: 1'b1, addr: 16'h4440, wr: 1'b1});
    @(negedge clk);
    checks++;
    if ({pmem_read, pmem_write} !== 2'b01 || pmem_wdata !== wd) begin
      failures++;
      $display("FAIL d_write_grant: rd=%b wr=%b wdata=%h required rd=0 wr=1 wdata=%h",
               pmem_read, pmem_write, pmem_wdata, wd);
    end
    d_wdata   = ~wd;
    d_address = 16'h0000;
    @(negedge clk);
    checks++;
    if (pmem_wdata !== wd || pmem_address !== 16'h4440) begin
      failures++;
      $display("FAIL d_write_hold: wdata=%h addr=%h required wdata=%h addr=4440",
               pmem_wdata, pmem_address, wd);
    end
    wait_done(20);
    checks++;
    if (i_wait_cnt !== 16'd1 || d_wait_cnt !== 16'd1) begin
      failures++;
      $display("FAIL d_write_wait: i=%0d d=%0d required i=1 d=1", i_wait_cnt, d_wait_cnt);
    end
  endtask

  task automatic test_tie();
    do_reset();
    mem_lat = 3;
    @(negedge clk);
    i_address = 16'h2000;
    d_address = 16'h3000;
    i_read    = 1'b1;
    d_read    = 1'b1;
    sb.push_back('{is_d: 1'b1, addr: 16'h3000, wr: 1'b0});
    sb.push_back('{is_d: 1'b0, addr: 16'h2000, wr: 1'b0});
    wait_done(40);
    // I waits one IDLE cycle, the whole D transfer, then the turnaround IDLE cycle.
    checks++;
    if (i_wait_cnt !== 16'(mem_lat + 2) || d_wait_cnt !== 16'd1) begin
      failures++;
      $display("FAIL tie_wait: i=%0d d=%0d required i=%0d d=1", i_wait_cnt, d_wait_cnt, mem_lat + 2);
    end
  endtask

  task automatic test_round_robin();
    int i_sent, d_sent, ni0, nd0;
    do_reset();
    mem_lat = 2;
    ni0 = n_i_resp;
    nd0 = n_d_resp;
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{is_d: 1'b1, addr: 16'h3000 + 16'(k * 16), wr: 1'b0});
      sb.push_back('{is_d: 1'b0, addr: 16'h1000 + 16'(k * 16), wr: 1'b0});
    end
    @(negedge clk);
    i_address = 16'h1000;
    d_address = 16'h3000;
    i_read    = 1'b1;
    d_read    = 1'b1;
    i_sent    = 1;
    d_sent    = 1;
    for (int c = 0; c < 200 && (i_sent < 3 || d_sent < 3 || i_read || d_read); c++) begin
      @(negedge clk);
      if (i_resp) i_read = 1'b0;
      else if (!i_read && i_sent < 3) begin
        i_address = 16'h1000 + 16'(i_sent * 16);
        i_read    = 1'b1;
        i_sent++;
      end
      if (d_resp) d_read = 1'b0;
      else if (!d_read && d_sent < 3) begin
        d_address = 16'h3000 + 16'(d_sent * 16);
        d_read    = 1'b1;
        d_sent++;
      end
    end
    wait_done(10);
    checks++;
    if (n_i_resp - ni0 != 3 || n_d_resp - nd0 != 3) begin
      failures++;
      $display("FAIL rr_count: i=%0d d=%0d required i=3 d=3", n_i_resp - ni0, n_d_resp - nd0);
    end
  endtask

  task automatic test_reset_mid();
    mem_lat = 100000;
    @(negedge clk);
    d_address = 16'h5550;
    d_wdata   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    d_write   = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (pmem_write !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_pre: pmem_write=%b required 1", pmem_write);
    end
    reset   = 1'b1;
    d_write = 1'b0;
    #1;
    checks++;
    if ({pmem_read, pmem_write} !== 2'b00 || pmem_address !== 16'h0) begin
      failures++;
      $display("FAIL reset_mid_async: rd=%b wr=%b addr=%h required rd=0 wr=0 addr=0",
               pmem_read, pmem_write, pmem_address);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (i_wait_cnt !== 16'h0 || d_wait_cnt !== 16'h0 || {pmem_read, pmem_write} !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid_post: i=%h d=%h rd=%b wr=%b required all 0",
               i_wait_cnt, d_wait_cnt, pmem_read, pmem_write);
    end
    mem_lat   = 2;
    i_address = 16'h2100;
    d_address = 16'h3100;
    i_read    = 1'b1;
    d_read    = 1'b1;
    sb.push_back('{is_d: 1'b1, addr: 16'h3100, wr: 1'b0});
    sb.push_back('{is_d: 1'b0, addr: 16'h2100, wr: 1'b0});
    wait_done(40);
  endtask

  task automatic test_saturation();
    do_reset();
    mem_lat = 100000;
    @(negedge clk);
    d_address = 16'h6000;
    d_read    = 1'b1;
    sb.push_back('{is_d: 1'b1, addr: 16'h6000, wr: 1'b0});
    @(negedge clk);
    i_address = 16'h7000;
    i_read    = 1'b1;
    sb.push_back('{is_d: 1'b0, addr: 16'h7000, wr: 1'b0});
    repeat (65600) @(negedge clk);
    checks++;
    if (i_wait_cnt !== 16'hFFFF || d_wait_cnt !== 16'd1) begin
      failures++;
      $display("FAIL sat_value: i=%h d=%h required i=ffff d=0001", i_wait_cnt, d_wait_cnt);
    end
    stat_clear = 1'b1;
    @(negedge clk);
    stat_clear = 1'b0;
    checks++;
    if (i_wait_cnt !== 16'h0 || d_wait_cnt !== 16'h0) begin
      failures++;
      $display("FAIL sat_clear: i=%h d=%h required 0", i_wait_cnt, d_wait_cnt);
    end
    @(negedge clk);
    checks++;
    if (i_wait_cnt !== 16'd1) begin
      failures++;
      $display("FAIL sat_restart: i=%h required 0001", i_wait_cnt);
    end
    mem_lat = 1;
    wait_done(20);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    mem_lat    = 3;
    reset      = 1'b1;
    i_read     = 1'b0;
    d_read     = 1'b0;
    d_write    = 1'b0;
    i_address  = '0;
    d_address  = '0;
    d_wdata    = '0;
    stat_clear = 1'b0;
    test_reset();
    test_lone_i_read();
    test_d_write();
    test_tie();
    test_round_robin();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
